// File: rtl/float_pkg.sv
// Shared float helpers: reduction FSM states, canonical quiet NaN, NaN detect.
// Helpers take widths as arguments and work on words up to 64 bits.
package float_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int FW_MAX = 64;

  function automatic logic [FW_MAX-1:0] exp_mask(input int data_w, input int exp_w);
    return ((FW_MAX'(1) << exp_w) - FW_MAX'(1)) << (data_w - 1 - exp_w);
  endfunction

  // Sign 0, exponent all ones, mantissa MSB set, remaining mantissa bits 0.
  function automatic logic [FW_MAX-1:0] canon_nan(input int data_w, input int exp_w);
    return exp_mask(data_w, exp_w) | (FW_MAX'(1) << (data_w - 2 - exp_w));
  endfunction

  function automatic logic is_nan(input logic [FW_MAX-1:0] x, input int data_w, input int exp_w);
    logic [FW_MAX-1:0] em;
    logic [FW_MAX-1:0] mm;
    em = exp_mask(data_w, exp_w);
    mm = (FW_MAX'(1) << (data_w - 1 - exp_w)) - FW_MAX'(1);
    return ((x & em) == em) && ((x & mm) != '0);
  endfunction

endpackage

// File: rtl/float_gt_cmp.sv
// Combinational sign-magnitude float compare: gt = (a > b), forced to 0 if either is NaN.
// Zero latency, no handshake.
module float_gt_cmp
  import float_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              a_nan,
  output logic              b_nan
);

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-2:0] a_mag;
  logic [DATA_W-2:0] b_mag;

  assign a_neg = a[DATA_W-1];
  assign b_neg = b[DATA_W-1];
  assign a_mag = a[DATA_W-2:0];
  assign b_mag = b[DATA_W-2:0];

  assign a_nan = is_nan(FW_MAX'(a), DATA_W, EXP_W);
  assign b_nan = is_nan(FW_MAX'(b), DATA_W, EXP_W);

  always_comb begin
    gt = 1'b0;
    if (!(a_nan || b_nan)) begin
      if (a_neg != b_neg)
        gt = !a_neg;             // mixed signs: positive wins, so +0 > -0
      else if (a_neg)
        gt = a_mag < b_mag;
      else
        gt = a_mag > b_mag;
    end
  end

endmodule

// File: rtl/float_max_reduce.sv
// Streaming float max reduction with first-occurrence index; done 1 cycle after last accepted sample.
// running=0 freezes everything (including a pending done); samples only accepted in ACCUM.
module float_max_reduce
  import float_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic [IDX_W-1:0]  length,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  output logic [DATA_W-1:0] out0,
  output logic [IDX_W-1:0]  out1,
  output logic              nan_seen,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] NAN_C = DATA_W'(canon_nan(DATA_W, EXP_W));

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  len_q, len_nxt;
  logic [IDX_W-1:0]  cnt, cnt_nxt;
  logic              have_max, have_max_nxt;
  logic              nan_nxt;
  logic [DATA_W-1:0] out0_nxt;
  logic [IDX_W-1:0]  out1_nxt;
  logic              in_gt, in_nan, max_nan;

  float_gt_cmp #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_cmp (
    .a     (in0),
    .b     (out0),
    .gt    (in_gt),
    .a_nan (in_nan),
    .b_nan (max_nan)
  );

  assign busy = (state == ACCUM);
  assign done = (state == FINISH) && running;

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    cnt_nxt      = cnt;
    have_max_nxt = have_max;
    nan_nxt      = nan_seen;
    out0_nxt     = out0;
    out1_nxt     = out1;
    if (running) begin
      if (run) begin
        len_nxt      = length;
        cnt_nxt      = '0;
        have_max_nxt = 1'b0;
        nan_nxt      = 1'b0;
        out0_nxt     = '0;
        out1_nxt     = '0;
        state_nxt    = (length == '0) ? FINISH : ACCUM;
      end else begin
        case (state)
          ACCUM: begin
            if (in0_valid) begin
              cnt_nxt = cnt + IDX_W'(1);
              if (in_nan) begin
                nan_nxt = 1'b1;
              end else if (!have_max || max_nan || in_gt) begin
                out0_nxt     = in0;
                out1_nxt     = cnt;
                have_max_nxt = 1'b1;
              end
              if (cnt == len_q - IDX_W'(1))
                state_nxt = FINISH;
            end
          end
          FINISH:  state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
      // Substitute the NaN result on entry to FINISH so it is visible alongside done.
      if (state_nxt == FINISH && !have_max_nxt) begin
        out0_nxt = NAN_C;
        out1_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      have_max <= 1'b0;
      nan_seen <= 1'b0;
      out0     <= '0;
      out1     <= '0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      cnt      <= cnt_nxt;
      have_max <= have_max_nxt;
      nan_seen <= nan_nxt;
      out0     <= out0_nxt;
      out1     <= out1_nxt;
    end
  end

endmodule

// File: tb/tb_float_max_reduce.sv
// Directed bench for float_max_reduce: table of reductions plus hand-written handshake,
// hold, abort and async-reset sequences.
module tb_float_max_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        running;
  logic [15:0] length;
  logic [31:0] in0;
  logic        in0_valid;
  logic [31:0] out0;
  logic [15:0] out1;
  logic        nan_seen;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  float_max_reduce #(.DATA_W(32), .EXP_W(8), .IDX_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .running   (running),
    .length    (length),
    .in0       (in0),
    .in0_valid (in0_valid),
    .out0      (out0),
    .out1      (out1),
    .nan_seen  (nan_seen),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][31:0] s;
    logic [31:0]      e_max;
    logic [15:0]      e_idx;
    logic             e_nan;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] len, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3, input logic [31:0] e_max,
                              input logic [15:0] e_idx, input logic e_nan);
    vec_t v;
    v.len   = len;
    v.s[0]  = s0;
    v.s[1]  = s1;
    v.s[2]  = s2;
    v.s[3]  = s3;
    v.e_max = e_max;
    v.e_idx = e_idx;
    v.e_nan = e_nan;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len);
    run    = 1'b1;
    length = len;
    step();
    run    = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    start(v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      in0       = v.s[i];
      in0_valid = 1'b1;
      step();
    end
    in0_valid = 1'b0;
    chk($sformatf("v%0d_done", k), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_out0", k), out0, v.e_max);
    chk($sformatf("v%0d_out1", k), {16'd0, out1}, {16'd0, v.e_idx});
    chk($sformatf("v%0d_nan", k), {31'd0, nan_seen}, {31'd0, v.e_nan});
    step();
    chk($sformatf("v%0d_done_off", k), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_hold", k), out0, v.e_max);
  endtask

  vec_t vt[9];
  int   pulses;

  initial begin
    vt[0] = mk(16'd4, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40000000, 32'h40000000, 16'd1, 1'b0);
    vt[1] = mk(16'd3, 32'hC0000000, 32'hBF800000, 32'hC0400000, 32'h0,        32'hBF800000, 16'd1, 1'b0);
    vt[2] = mk(16'd2, 32'h80000000, 32'h00000000, 32'h0,        32'h0,        32'h00000000, 16'd1, 1'b0);
    vt[3] = mk(16'd2, 32'h00000000, 32'h80000000, 32'h0,        32'h0,        32'h00000000, 16'd0, 1'b0);
    vt[4] = mk(16'd3, 32'h7FC00001, 32'h3F800000, 32'h7F800000, 32'h0,        32'h7F800000, 16'd2, 1'b1);
    vt[5] = mk(16'd2, 32'h7FC00000, 32'h7FF00000, 32'h0,        32'h0,        32'h7FC00000, 16'd0, 1'b1);
    vt[6] = mk(16'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h7FC00000, 16'd0, 1'b0);
    vt[7] = mk(16'd3, 32'h3F800000, 32'h3F800000, 32'h3F7FFFFF, 32'h0,        32'h3F800000, 16'd0, 1'b0);
    vt[8] = mk(16'd1, 32'hFF800000, 32'h0,        32'h0,        32'h0,        32'hFF800000, 16'd0, 1'b0);

    rst = 1'b0; run = 1'b0; running = 1'b1; length = '0; in0 = '0; in0_valid = 1'b0;
    #12;
    chk("rst_out0", out0, 32'h0);
    chk("rst_out1", {16'd0, out1}, 32'h0);
    chk("rst_flags", {29'd0, nan_seen, busy, done}, 32'h0);
    rst = 1'b1;
    step();

    for (int k = 0; k < 9; k++) apply_vec(vt[k], k);

    // valid gaps 1,0,1,0,1 with junk on the idle cycles
    start(16'd3);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      in0_valid = (i % 2 == 0);
      in0 = (i == 0) ? 32'h3F800000 : (i == 2) ? 32'h40400000 : (i == 4) ? 32'h40000000 : 32'h7F000000;
      step();
      pulses += int'(done);
    end
    in0_valid = 1'b0;
    chk("gap_done_at_end", {31'd0, done}, 32'd1);
    step();
    pulses += int'(done);
    chk("gap_pulses", pulses, 32'd1);
    chk("gap_out0", out0, 32'h40400000);
    chk("gap_out1", {16'd0, out1}, 32'd1);

    // running drops mid-stream and again while done is pending
    start(16'd3);
    in0 = 32'h3F800000; in0_valid = 1'b1;
    step();
    running = 1'b0; in0 = 32'h7F000000;
    step();
    run = 1'b1; length = 16'd0;
    step();
    run = 1'b0;
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_out0", out0, 32'h3F800000);
    running = 1'b1; in0 = 32'h40000000;
    step();
    in0 = 32'h40400000;
    step();
    in0_valid = 1'b0; running = 1'b0;
    #1;
    chk("hold_done_pending", {31'd0, done}, 32'd0);
    step();
    chk("hold_done_still", {31'd0, done}, 32'd0);
    running = 1'b1;
    #1;
    chk("hold_done_resume", {31'd0, done}, 32'd1);
    chk("hold_out0_final", out0, 32'h40400000);
    chk("hold_out1_final", {16'd0, out1}, 32'd2);
    step();
    chk("hold_done_once", {31'd0, done}, 32'd0);

    // abort after 2 samples; the sample alongside run is dropped
    start(16'd4);
    pulses = 0;
    in0_valid = 1'b1;
    in0 = 32'h7F000000; step(); pulses += int'(done);
    in0 = 32'h00000000; step(); pulses += int'(done);
    run = 1'b1; length = 16'd2; in0 = 32'h7F700000;
    step(); pulses += int'(done);
    run = 1'b0;
    chk("abort_cleared", out0, 32'h0);
    in0 = 32'h3F800000; step(); pulses += int'(done);
    chk("abort_no_done", pulses, 32'd0);
    in0 = 32'hBF800000; step();
    in0_valid = 1'b0;
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_out0", out0, 32'h3F800000);
    chk("abort_out1", {16'd0, out1}, 32'd0);
    step();

    // async reset while accumulating
    start(16'd3);
    in0_valid = 1'b1;
    in0 = 32'h7FC00000; step();
    in0 = 32'h40000000; step();
    in0_valid = 1'b0;
    chk("pre_rst_out0", out0, 32'h40000000);
    chk("pre_rst_flags", {30'd0, nan_seen, busy}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_out0", out0, 32'h0);
    chk("arst_out1", {16'd0, out1}, 32'h0);
    chk("arst_flags", {29'd0, nan_seen, busy, done}, 32'h0);
    #1 rst = 1'b1;
    step();
    chk("arst_idle", {30'd0, busy, done}, 32'd0);
    apply_vec(vt[1], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
